// File: rtl/audio_voice_scheduler.sv
// Sample-rate sequencer: divides clk to the audio sample tick, then walks every
// voice through one shared engine and presents the saturated mix to the DAC pair.
module audio_voice_scheduler #(
  parameter int NUM_VOICES = 4,
  parameter int VIDX_W     = 2,
  parameter int CLK_DIV    = 1500,
  parameter int SAMPLE_W   = 12,
  parameter int ACC_W      = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       enable,
  output logic                       voice_req,
  output logic [VIDX_W-1:0]          voice_idx,
  input  logic                       voice_ack,
  input  logic signed [SAMPLE_W-1:0] voice_sample,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       sample_valid,
  output logic                       overrun,
  input  logic                       overrun_clr,
  output logic [1:0]                 state_dbg
);

  // Engine handshake: voice_req/voice_idx are held from the first REQ cycle
  // until the cycle voice_ack is seen high; that cycle transfers voice_sample.
  // voice_req always drops for at least one cycle between two requests.

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [VIDX_W-1:0]       IDX_LAST = VIDX_W'(NUM_VOICES - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((2 ** (SAMPLE_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-(2 ** (SAMPLE_W - 1)));

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_GAP    = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  state_t                       state_q, state_d;
  logic [DIV_W-1:0]             div_cnt_q, div_cnt_d;
  logic [VIDX_W-1:0]            idx_q, idx_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic                         req_q, req_d;
  logic signed [SAMPLE_W-1:0]   sample_q, sample_d;
  logic                         valid_q, valid_d;
  logic                         overrun_q, overrun_d;

  logic                         tick;
  logic signed [ACC_W-1:0]      sample_ext;
  logic signed [SAMPLE_W-1:0]   sat_acc;

  assign tick       = enable && (div_cnt_q == DIV_LAST);
  assign sample_ext = {{(ACC_W - SAMPLE_W){voice_sample[SAMPLE_W-1]}}, voice_sample};

  always_comb begin
    if (acc_q > SAT_MAX) begin
      sat_acc = SAT_MAX[SAMPLE_W-1:0];
    end else if (acc_q < SAT_MIN) begin
      sat_acc = SAT_MIN[SAMPLE_W-1:0];
    end else begin
      sat_acc = acc_q[SAMPLE_W-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    req_d     = req_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;

    if (!enable || (div_cnt_q == DIV_LAST)) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end

    // A tick during a frame is only flagged; it never restarts or queues a frame.
    overrun_d = (overrun_q && !overrun_clr) || (tick && (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          acc_d   = '0;
          idx_d   = '0;
          req_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (voice_ack) begin
          acc_d = acc_q + sample_ext;
          req_d = 1'b0;
          if (idx_q == IDX_LAST) begin
            state_d = S_OUTPUT;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        req_d   = 1'b1;
        state_d = S_REQ;
      end
      S_OUTPUT: begin
        sample_d = sat_acc;
        valid_d  = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      div_cnt_q <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      req_q     <= 1'b0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      req_q     <= req_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign voice_req    = req_q;
  assign voice_idx    = idx_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_audio_voice_scheduler.sv
// Bench for audio_voice_scheduler: a scripted voice engine with programmable
// per-voice samples and ack delays, checked against a frame-level mix/timing model.
module tb_audio_voice_scheduler;

  localparam int NV   = 4;
  localparam int CDIV = 20;
  localparam int SW   = 12;

  logic                 clk;
  logic                 resetn;
  logic                 enable;
  logic                 voice_req;
  logic [1:0]           voice_idx;
  logic                 voice_ack;
  logic signed [SW-1:0] voice_sample;
  logic signed [SW-1:0] sample_out;
  logic                 sample_valid;
  logic                 overrun;
  logic                 overrun_clr;
  logic [1:0]           state_dbg;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic signed [SW-1:0] eng_samp [NV];
  int                   eng_wait [NV];
  bit                   noise_en = 0;

  audio_voice_scheduler #(
    .NUM_VOICES(NV), .VIDX_W(2), .CLK_DIV(CDIV), .SAMPLE_W(SW), .ACC_W(16)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .voice_req(voice_req), .voice_idx(voice_idx),
    .voice_ack(voice_ack), .voice_sample(voice_sample),
    .sample_out(sample_out), .sample_valid(sample_valid),
    .overrun(overrun), .overrun_clr(overrun_clr), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Engine: acks voice k after eng_wait[k] stall cycles; random ack/data noise otherwise.
  initial begin
    int wcnt;
    wcnt = 0;
    voice_ack = 1'b0;
    voice_sample = '0;
    forever begin
      @(negedge clk);
      if (voice_req === 1'b1) begin
        if (wcnt >= eng_wait[voice_idx]) begin
          voice_ack    = 1'b1;
          voice_sample = eng_samp[voice_idx];
        end else begin
          voice_ack    = 1'b0;
          voice_sample = SW'($urandom);
          wcnt++;
        end
      end else begin
        wcnt         = 0;
        voice_ack    = noise_en && ($urandom_range(0, 1) == 1);
        voice_sample = SW'($urandom);
      end
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_voices(input int s0, input int s1, input int s2, input int s3,
                            input int w0, input int w1, input int w2, input int w3);
    eng_samp[0] = SW'(s0); eng_samp[1] = SW'(s1);
    eng_samp[2] = SW'(s2); eng_samp[3] = SW'(s3);
    eng_wait[0] = w0; eng_wait[1] = w1; eng_wait[2] = w2; eng_wait[3] = w3;
  endtask

  // Observes one whole frame and compares it with the frame-level model:
  // mix = clamp(sum of engine samples), tick-to-valid = 2*NV+1 plus stall cycles.
  task automatic run_frame(input string tag, input int exp_start, input bit drop_en,
                           output int t_req);
    int sum, wsum, expv, code, exp_code, reqc, t_val;
    bit prev, got, started;
    sum = 0; wsum = 0; code = 0; exp_code = 0; reqc = 0; t_val = 0;
    prev = 0; got = 0; started = 0;
    for (int i = 0; i < NV; i++) begin
      sum      += int'(eng_samp[i]);
      wsum     += eng_wait[i];
      exp_code  = exp_code * 8 + i + 1;
    end
    expv = (sum > 2047) ? 2047 : (sum < -2048) ? -2048 : sum;

    for (int n = 0; n < 60 && !started; n++) begin
      if (voice_req === 1'b1) started = 1;
      else @(negedge clk);
    end
    t_req = cyc;
    check({tag, "_started"}, int'(started), 1);
    if (!started) return;
    check({tag, "_start_cycle"}, t_req, exp_start);

    for (int n = 0; n < 80 && !got; n++) begin
      if (voice_req === 1'b1) reqc++;
      if (voice_req === 1'b1 && !prev) code = code * 8 + int'(voice_idx) + 1;
      prev = (voice_req === 1'b1);
      if (drop_en && voice_req === 1'b1 && voice_idx == 2'd1) enable = 1'b0;
      if (sample_valid === 1'b1) begin
        got   = 1;
        t_val = cyc;
      end else begin
        @(negedge clk);
      end
    end
    check({tag, "_valid_seen"}, int'(got), 1);
    if (!got) return;
    check({tag, "_mix"}, int'(sample_out), expv);
    check({tag, "_latency"}, t_val - t_req, 2 * NV + wsum);
    check({tag, "_idx_seq"}, code, exp_code);
    check({tag, "_req_cycles"}, reqc, NV + wsum);
    @(negedge clk);
    check({tag, "_pulse"}, int'(sample_valid), 0);
    check({tag, "_hold"}, int'(sample_out), expv);
  endtask

  initial begin
    int t, nxt, r, bad;
    bit found;
    resetn = 1'b0;
    enable = 1'b0;
    overrun_clr = 1'b0;
    set_voices(0, 0, 0, 0, 0, 0, 0, 0);

    // reset state
    repeat (3) @(negedge clk);
    check("rst_voice_req", int'(voice_req), 0);
    check("rst_voice_idx", int'(voice_idx), 0);
    check("rst_sample_out", int'(sample_out), 0);
    check("rst_sample_valid", int'(sample_valid), 0);
    check("rst_overrun", int'(overrun), 0);

    resetn = 1'b1;
    noise_en = 1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (voice_req !== 1'b0 || sample_valid !== 1'b0) bad++;
    end
    check("disabled_no_activity", bad, 0);

    // first tick CDIV-1 cycles after enable, request one cycle later
    enable = 1'b1;
    nxt = cyc + CDIV;
    set_voices(100, 200, 300, 400, 0, 0, 0, 0);
    run_frame("basic", nxt, 0, t);
    nxt = t + CDIV;

    set_voices(2047, 2047, 2047, 2047, 0, 0, 0, 0);
    run_frame("clamp_pos", nxt, 0, t);
    nxt = t + CDIV;

    set_voices(-2048, -2048, -2048, -2048, 0, 0, 0, 0);
    run_frame("clamp_neg", nxt, 0, t);
    nxt = t + CDIV;

    set_voices(100, 200, 300, 400, 0, 0, 3, 0);
    run_frame("ack_wait", nxt, 0, t);
    nxt = t + CDIV;

    for (int k = 0; k < 10; k++) begin
      set_voices($urandom_range(0, 4095), $urandom_range(0, 4095),
                 $urandom_range(0, 4095), $urandom_range(0, 4095),
                 $urandom_range(0, 2), $urandom_range(0, 2),
                 $urandom_range(0, 2), $urandom_range(0, 2));
      run_frame("rand", nxt, 0, t);
      nxt = t + CDIV;
    end
    check("no_overrun_normal", int'(overrun), 0);

    // stall voice 0 past the next tick: that tick is dropped, frame still completes
    set_voices(-700, 50, 1234, -3, 15, 0, 0, 0);
    run_frame("stall", nxt, 0, t);
    check("overrun_set", int'(overrun), 1);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (sample_valid !== 1'b0 || voice_req !== 1'b0) bad++;
    end
    check("stall_single_valid", bad, 0);
    check("overrun_sticky", int'(overrun), 1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("overrun_cleared", int'(overrun), 0);
    nxt = t + 2 * CDIV;
    set_voices(-1, -2, -3, -4, 1, 0, 0, 1);
    run_frame("after_ovr", nxt, 0, t);

    // reset while voice 1 is being requested
    set_voices(500, 600, 700, 800, 0, 5, 0, 0);
    found = 0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(negedge clk);
      if (voice_req === 1'b1 && voice_idx == 2'd1) found = 1;
    end
    check("midframe_req_v1_seen", int'(found), 1);
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_voice_req", int'(voice_req), 0);
    check("midrst_sample_out", int'(sample_out), 0);
    check("midrst_sample_valid", int'(sample_valid), 0);
    resetn = 1'b1;
    r = cyc;
    set_voices(10, -20, 30, -40, 0, 0, 0, 0);
    run_frame("post_reset", r + CDIV, 0, t);

    // enable dropped during voice 1: frame finishes, then silence
    set_voices(1500, 1500, -100, 7, 0, 1, 0, 0);
    run_frame("en_drop", t + CDIV, 1, t);
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (sample_valid !== 1'b0 || voice_req !== 1'b0) bad++;
    end
    check("en_drop_silent", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
